// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: request side (instr/immsrc) and
// response side (immext/illegal), each with its own valid/ready pair.
interface imm_extend_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SRC_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [24:0]      instr;
  logic [SRC_W-1:0] immsrc;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  immext;
  logic             illegal;

  modport master (
    output in_valid, instr, immsrc, out_ready,
    input  in_ready, out_valid, immext, illegal
  );

  modport slave (
    input  in_valid, instr, immsrc, out_ready,
    output in_ready, out_valid, immext, illegal
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined RISC-V immediate generator (I/S/B/J/U) behind a 2-entry skid buffer
// so that in_ready comes straight from a flop.
module imm_extend_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SRC_W = 3
) (
  input logic              clk,
  input logic              rst_n,
  input logic              flush,
  imm_extend_pipe_if.slave bus
);

  typedef enum logic [1:0] {StEmpty = 2'd0, StOne = 2'd1, StFull = 2'd2} state_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic            ill;
  } entry_t;

  logic [31:7] ir;
  logic [31:0] imm32;
  entry_t      in_entry;
  state_e      state_q, state_d;
  entry_t      main_q, main_d;
  entry_t      skid_q, skid_d;
  logic        in_ready_q;
  logic        accept, emit;

  assign ir = bus.instr;

  // Every format places the sign bit at bit 31, so one 32->XLEN extension serves all.
  always_comb begin
    imm32        = '0;
    in_entry.ill = 1'b0;
    case (bus.immsrc)
      SRC_W'(0): imm32 = {{20{ir[31]}}, ir[31:20]};
      SRC_W'(1): imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      SRC_W'(2): imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      SRC_W'(3): imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      SRC_W'(4): imm32 = {ir[31:12], 12'h000};
      default:   in_entry.ill = 1'b1;
    endcase
    in_entry.imm = XLEN'($signed(imm32));
  end

  assign accept = bus.in_valid & in_ready_q;
  assign emit   = (state_q != StEmpty) & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_d  = in_entry;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && !emit) begin
            skid_d  = in_entry;
            state_d = StFull;
          end else if (emit && !accept) begin
            state_d = StEmpty;
          end else if (accept && emit) begin
            main_d = in_entry;
          end
        end
        StFull: begin
          if (emit) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != StFull);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != StEmpty);
  assign bus.immext    = main_q.imm;
  assign bus.illegal   = main_q.ill;

endmodule
